// File: rtl/fix_ari_mul.sv
// Three-stage signed fixed-point multiplier: full product plus a Q(WIDTH-FRAC).FRAC
// re-quantised copy. One operand pair per cycle, no stalls.
module fix_ari_mul #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [WIDTH-1:0]  data_in1,
  input  logic signed [WIDTH-1:0]  data_in2,
  output logic signed [2*WIDTH-2:0] data_out,
  output logic signed [WIDTH-1:0]  data_out_round
);

  localparam int H  = WIDTH - FRAC;   // signed high half width
  localparam int PW = 2*WIDTH - 1;    // product width
  localparam int MW = H + FRAC + 1;   // signed-high x unsigned-low product width

  typedef struct packed {
    logic signed [2*H-1:0]    hh;
    logic signed [MW-1:0]     hl;
    logic signed [MW-1:0]     lh;
    logic        [2*FRAC-1:0] ll;
  } pp_t;

  // S1: operand registers
  logic signed [WIDTH-1:0] a_q, b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= data_in1;
      b_q <= data_in2;
    end
  end

  // S2: split each operand as hi*2^FRAC + lo, hi signed, lo unsigned
  logic signed [H-1:0]      ah, bh;
  logic        [FRAC-1:0]   al, bl;
  logic signed [2*H-1:0]    ah_w, bh_w;
  logic signed [MW-1:0]     ah_m, bh_m, al_m, bl_m;
  logic        [2*FRAC-1:0] al_w, bl_w;
  pp_t                      pp_d, pp_q;

  assign ah = a_q[WIDTH-1:FRAC];
  assign bh = b_q[WIDTH-1:FRAC];
  assign al = a_q[FRAC-1:0];
  assign bl = b_q[FRAC-1:0];

  // Operands pre-extended to the product width so each multiply is exact.
  assign ah_w = {{H{ah[H-1]}}, ah};
  assign bh_w = {{H{bh[H-1]}}, bh};
  assign ah_m = {{(MW-H){ah[H-1]}}, ah};
  assign bh_m = {{(MW-H){bh[H-1]}}, bh};
  assign al_m = {{(MW-FRAC){1'b0}}, al};
  assign bl_m = {{(MW-FRAC){1'b0}}, bl};
  assign al_w = {{FRAC{1'b0}}, al};
  assign bl_w = {{FRAC{1'b0}}, bl};

  always_comb begin
    pp_d    = '0;
    pp_d.hh = ah_w * bh_w;
    pp_d.hl = ah_m * bl_m;
    pp_d.lh = al_m * bh_m;
    pp_d.ll = al_w * bl_w;
  end

  always_ff @(posedge clk) begin
    if (rst) pp_q <= '0;
    else     pp_q <= pp_d;
  end

  // S3: align and sum modulo 2^PW; only (-2^(WIDTH-1))^2 wraps
  logic signed [PW-1:0] hh_x, hl_x, lh_x, ll_x, sum;

  assign hh_x = {{(PW-2*H){pp_q.hh[2*H-1]}}, pp_q.hh};
  assign hl_x = {{(PW-MW){pp_q.hl[MW-1]}}, pp_q.hl};
  assign lh_x = {{(PW-MW){pp_q.lh[MW-1]}}, pp_q.lh};
  assign ll_x = {{(PW-2*FRAC){1'b0}}, pp_q.ll};
  assign sum  = (hh_x <<< (2*FRAC)) + ((hl_x + lh_x) <<< FRAC) + ll_x;

  always_ff @(posedge clk) begin
    if (rst) data_out <= '0;
    else     data_out <= sum;
  end

  // Keep sign, floor away FRAC LSBs, wrap the high integer bits.
  assign data_out_round = {data_out[PW-1], data_out[WIDTH+FRAC-2:WIDTH],
                           data_out[WIDTH-1:FRAC]};

endmodule

// File: tb/tb_fix_ari_mul.sv
// Directed checks for fix_ari_mul: reset, latency, sign/quantise corners,
// a ramp against a 3-deep reference pipeline, and a mid-stream reset.
module tb_fix_ari_mul;

  logic               clk;
  logic               rst;
  logic signed [15:0] data_in1, data_in2;
  logic signed [30:0] data_out;
  logic signed [15:0] data_out_round;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [30:0] m1 = '0, m2 = '0, m_out = '0;

  fix_ari_mul #(.WIDTH(16), .FRAC(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in1       (data_in1),
    .data_in2       (data_in2),
    .data_out       (data_out),
    .data_out_round (data_out_round)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [30:0] prod(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    logic signed [30:0] ax, bx;
    ax = 31'(a);
    bx = 31'(b);
    return ax * bx;
  endfunction

  function automatic logic signed [15:0] rnd(input logic signed [30:0] p);
    return {p[30], p[22:16], p[15:8]};
  endfunction

  // Drive one cycle, step past the edge, advance the reference pipeline.
  task automatic cyc(input logic signed [15:0] a, input logic signed [15:0] b,
                     input logic r);
    data_in1 = a;
    data_in2 = b;
    rst      = r;
    @(posedge clk);
    #1;
    m_out = r ? '0 : m2;
    m2    = r ? '0 : m1;
    m1    = r ? '0 : prod(a, b);
  endtask

  initial begin
    data_in1 = '0;
    data_in2 = '0;
    rst      = 1'b1;

    // reset held with nonzero operands
    cyc(16'sd100, 16'sd100, 1'b1);
    chk("rst0_out", data_out, 0);
    chk("rst0_rnd", data_out_round, 0);
    cyc(16'sd100, 16'sd100, 1'b1);
    chk("rst1_out", data_out, 0);
    chk("rst1_rnd", data_out_round, 0);

    // first post-reset operands appear after their third sampling edge
    cyc(16'sd512, 16'sd512, 1'b0);
    chk("rel0_out", data_out, 0);
    cyc(16'sd1, 16'sd1, 1'b0);
    chk("rel1_out", data_out, 0);
    chk("rel1_rnd", data_out_round, 0);
    cyc(16'sd2, 16'sd2, 1'b0);
    chk("rel2_out", data_out, 262144);
    chk("rel2_rnd", data_out_round, 1024);
    cyc(-16'sd200, -16'sd10, 1'b0);
    chk("one_out", data_out, 1);
    chk("one_rnd", data_out_round, 0);
    cyc(-16'sd256, 16'sd256, 1'b0);
    chk("four_out", data_out, 4);
    cyc(16'sd32767, 16'sd32767, 1'b0);
    chk("lat_out", data_out, 2000);
    chk("lat_rnd", data_out_round, 7);
    cyc(-16'sd32768, -16'sd32768, 1'b0);
    chk("neg1_out", data_out, -65536);
    chk("neg1_rnd", data_out_round, -256);
    cyc(-16'sd1, 16'sd1, 1'b0);
    chk("max_out", data_out, 1073676289);
    chk("max_rnd", data_out_round, 32512);
    cyc(16'sd0, 16'sd0, 1'b0);
    chk("wrap_out", data_out, -1073741824);
    chk("wrap_rnd", data_out_round, -32768);
    cyc(16'sd0, 16'sd0, 1'b0);
    chk("floor_out", data_out, -1);
    chk("floor_rnd", data_out_round, -1);

    // ramp with a one-edge reset pulse at i=60
    for (int i = 0; i < 100; i++) begin
      int a, b;
      a = -200 + 10*i;
      b = -10 + 2*i;
      cyc(16'(a), 16'(b), i == 60);
      chk("ramp_out", data_out, m_out);
      chk("ramp_rnd", data_out_round, rnd(m_out));
      if (i == 22) chk("ramp_zero", data_out, 0);
      if (i == 32) begin
        chk("ramp_5000", data_out, 5000);
        chk("ramp_r19", data_out_round, 19);
      end
      if (i >= 60 && i <= 62) chk("mrst_lost", data_out, 0);
      if (i == 63) chk("mrst_resume", data_out, 45920);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
